// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet builder.
// The CRC_SEND state exists only when PKT_BUILDER_CRC_EN is defined.
package pkt_pkg;

`ifdef PKT_BUILDER_CRC_EN
    typedef enum logic [2:0] {
        IDLE, ETH_HDR, IP_HDR, TCP_HDR, PAYLOAD, CRC_SEND
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ETH_HDR, IP_HDR, TCP_HDR, PAYLOAD
    } state_t;
`endif

    localparam int ETH_WORDS = 4;
    localparam int IP_WORDS  = 5;
    localparam int TCP_WORDS = 5;
    localparam int PAY_WORDS = 10;
    localparam int HDR_WORDS = ETH_WORDS + IP_WORDS + TCP_WORDS;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_word.sv
// Combinational CRC-32 (reflected) advance over one 32-bit word,
// consuming bit 0 first so byte [7:0] is processed first.
module crc32_word
    import pkt_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [31:0] data,
    output logic [31:0] crc_next
);

    always_comb begin
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC_POLY : 32'h0);
        end
        crc_next = c;
    end

endmodule

// File: rtl/packet_builder.sv
// Builds eth/ip/tcp header + 10 payload word packets on a valid/ready stream.
// Define PKT_BUILDER_CRC_EN to append a CRC-32 trailer word.
module packet_builder
    import pkt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [127:0]     eth_hdr,
    input  logic [159:0]     ip_hdr,
    input  logic [159:0]     tcp_hdr,
    input  logic [WIDTH-1:0] pay_data,
    input  logic             pay_valid,
    output logic             pay_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last
);

    localparam logic [4:0] ETH_LAST = 5'(ETH_WORDS - 1);
    localparam logic [4:0] IP_LAST  = 5'(ETH_WORDS + IP_WORDS - 1);
    localparam logic [4:0] TCP_LAST = 5'(HDR_WORDS - 1);
    localparam logic [4:0] PAY_LAST = 5'(HDR_WORDS + PAY_WORDS - 1);

    state_t                             state, state_n;
    logic [4:0]                         cnt;
    logic [HDR_WORDS-1:0][WIDTH-1:0]    hdr_q;
    logic                               xfer;

    assign xfer = tx_valid && tx_ready;

`ifdef PKT_BUILDER_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_nx;

    crc32_word u_crc (
        .crc      (crc_q),
        .data     (pay_data),
        .crc_next (crc_nx)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            hdr_q <= '0;
`ifdef PKT_BUILDER_CRC_EN
            crc_q <= CRC_INIT;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                cnt <= '0;
                if (start) hdr_q <= {tcp_hdr, ip_hdr, eth_hdr};
            end else if (xfer) begin
                cnt <= cnt + 5'd1;
            end
`ifdef PKT_BUILDER_CRC_EN
            if (state == IDLE) begin
                crc_q <= CRC_INIT;
            end else if (state == PAYLOAD && xfer) begin
                crc_q <= crc_nx;
            end
`endif
        end
    end

    always_comb begin
        state_n     = state;
        start_ready = 1'b0;
        tx_valid    = 1'b0;
        tx_last     = 1'b0;
        tx_data     = '0;
        pay_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start) state_n = ETH_HDR;
            end
            ETH_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_q[cnt[3:0]];
                if (tx_ready && cnt == ETH_LAST) state_n = IP_HDR;
            end
            IP_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_q[cnt[3:0]];
                if (tx_ready && cnt == IP_LAST) state_n = TCP_HDR;
            end
            TCP_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_q[cnt[3:0]];
                if (tx_ready && cnt == TCP_LAST) state_n = PAYLOAD;
            end
            PAYLOAD: begin
                // Payload is a straight pass-through of the FIFO handshake.
                tx_valid  = pay_valid;
                pay_ready = tx_ready;
                tx_data   = pay_data;
                if (cnt == PAY_LAST) begin
`ifdef PKT_BUILDER_CRC_EN
                    if (pay_valid && tx_ready) state_n = CRC_SEND;
`else
                    tx_last = pay_valid;
                    if (pay_valid && tx_ready) state_n = IDLE;
`endif
                end
            end
`ifdef PKT_BUILDER_CRC_EN
            CRC_SEND: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = ~crc_q;
                if (tx_ready) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule
